// File: rtl/maze_pkg.sv
// Shared widths, cell colour codes and FSM encoding for the maze frame server.
package maze_pkg;

    localparam int CELL_W = 2;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [CELL_W-1:0] CELL_OFF  = 2'd0;
    localparam logic [CELL_W-1:0] CELL_RED  = 2'd1;
    localparam logic [CELL_W-1:0] CELL_GRN  = 2'd2;
    localparam logic [CELL_W-1:0] CELL_BOTH = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWAP   = 2'd1,
        ST_UPLOAD = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

endpackage

// File: rtl/maze_frame_bank.sv
// Ping-pong frame store: game logic writes the back bank, the matrix bus reads the front bank.
module maze_frame_bank
    import maze_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CELL_W-1:0] wr_data,
    input  logic              swap,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CELL_W-1:0] rd_data
);

    logic              bank_sel;
    logic [CELL_W-1:0] mem [2][DEPTH];

    // A write in the swap cycle still targets the old back bank, which becomes front.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            bank_sel <= 1'b0;
            mem      <= '{default: '0};
        end else begin
            if (wr_en) begin
                mem[~bank_sel][wr_addr] <= wr_data;
            end
            if (swap) begin
                bank_sel <= ~bank_sel;
            end
        end
    end

    assign rd_data = mem[bank_sel][rd_addr];

endmodule

// File: rtl/maze_frame_server.sv
// Frame source for the 8x8 bicolour LED matrix driver: bank swap, 64-cycle upload window, refresh.
// Optional address/handshake checker enabled by defining SYNC_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for commit, pending commit or refresh expiry
// SWAP   | one cycle, flips front/back banks
// UPLOAD | enable high, counter 0..63 tracks the driver's address
// GAP    | enable low for GAP_CYCLES before returning to IDLE
module maze_frame_server
    import maze_pkg::*;
#(
    parameter int GAP_CYCLES     = 4,
    parameter int REFRESH_PERIOD = 0
)(
    input  logic              clk,
    input  logic              nrst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CELL_W-1:0] wr_data,
    input  logic              commit,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              enable,
    input  logic [ADDR_W-1:0] address,
    input  logic              command,
    output logic [CELL_W-1:0] data,
    output logic              sync_err
);

    localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int RT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [RT_W-1:0] RT_LAST  = RT_W'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] up_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [RT_W-1:0]   refresh_tmr;
    logic              pending;
    logic              swap;
    logic              refresh_hit;
    logic [CELL_W-1:0] rd_data;

    maze_frame_bank u_bank (
        .clk     (clk),
        .nrst    (nrst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .swap    (swap),
        .rd_addr (address),
        .rd_data (rd_data)
    );

    assign data        = command ? rd_data : CELL_OFF;
    assign busy        = (state != ST_IDLE) | pending;
    assign refresh_hit = (REFRESH_PERIOD != 0) && (refresh_tmr == RT_LAST);

    // enable is decoded from state so an async reset drops it immediately.
    always_comb begin
        state_nxt  = state;
        enable     = 1'b0;
        frame_done = 1'b0;
        swap       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit || pending) begin
                    state_nxt = ST_SWAP;
                end else if (refresh_hit) begin
                    state_nxt = ST_UPLOAD;
                end
            end
            ST_SWAP: begin
                swap      = 1'b1;
                state_nxt = ST_UPLOAD;
            end
            ST_UPLOAD: begin
                enable = 1'b1;
                if (up_cnt == {ADDR_W{1'b1}}) begin
                    frame_done = 1'b1;
                    state_nxt  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state       <= ST_IDLE;
            up_cnt      <= '0;
            gap_cnt     <= '0;
            refresh_tmr <= '0;
            pending     <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            state <= state_nxt;

            up_cnt <= (state == ST_UPLOAD) ? up_cnt + 1'b1 : '0;

            if (state != ST_GAP && state_nxt == ST_GAP) begin
                gap_cnt <= GAP_LAST;
            end else if (state == ST_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            if (REFRESH_PERIOD != 0 && state == ST_IDLE && state_nxt == ST_IDLE) begin
                refresh_tmr <= refresh_tmr + 1'b1;
            end else begin
                refresh_tmr <= '0;
            end

            // In IDLE a pending commit is consumed by the transition to SWAP.
            if (state == ST_IDLE) begin
                pending <= 1'b0;
            end else if (commit) begin
                pending <= 1'b1;
            end

            if (frame_done) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

`ifdef SYNC_CHECK_EN
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            sync_err <= 1'b0;
        end else if (state == ST_UPLOAD && (!command || address != up_cnt)) begin
            sync_err <= 1'b1;
        end
    end
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: doc/maze_frame_server.md
Name: maze_frame_server

Overview:
- Frame source and bus responder for the 8x8 bicolour LED matrix driver.
- Holds two 64-cell x 2-bit frame banks (ping-pong) written by maze game logic.
- On commit or refresh, drives enable for exactly 64 cycles and answers the driver's address/command bus with cell data on the data lines.
- Sits between game logic and the matrix driver; it is the other end of the driver's enable/address/command/data upload bus.

Parameters:
- CELL_W, 2, bits per cell (0 off, 1 red, 2 green, 3 both)
- ADDR_W, 6, cell address width; depth = 2**ADDR_W = 64
- GAP_CYCLES, 4, minimum idle cycles between uploads (>=1)
- REFRESH_PERIOD, 0, cycles between automatic re-uploads of the front bank; 0 disables

Ports:
- clk  in  1  system clock, 50 MHz
- nrst  in  1  asynchronous reset, active-high
- wr_en  in  1  game-side cell write strobe
- wr_addr  in  ADDR_W  cell index, row*8+col
- wr_data  in  CELL_W  cell colour
- commit  in  1  pulse: back bank complete, swap and upload
- busy  out  1  high outside IDLE or while a commit is pending
- frame_done  out  1  one-cycle pulse on the last upload cycle
- frame_cnt  out  8  completed uploads, wraps 255->0
- enable  out  1  upload window to the driver
- address  in  ADDR_W  driver's read address; valid when command==1
- command  in  1  driver acknowledges the window; z/0 is treated as inactive
- data  out  CELL_W  front[address] when command==1, else 0
- sync_err  out  1  sticky address-mismatch flag (SYNC_CHECK_EN only)

Behaviour:
- Reset is clk and nrst (asynchronous, active-high).
- Reset values:
  - Outputs: enable=0, busy=0, frame_done=0, frame_cnt=0, sync_err=0.
  - Internal: bank_sel=0, both banks cleared to 0, pending=0, state=IDLE, upload counter=0, refresh timer=0.
- Writes: on a clk edge with wr_en=1, bank[~bank_sel][wr_addr] <= wr_data. Writes are accepted in every state, with no back-pressure.
- data path:
  - Combinational: data = command ? bank[bank_sel][address] : 0.
  - Zero latency. The driver samples data on the same edge it increments address.
- FSM:
  - IDLE:
    - commit or pending -> SWAP; clear pending.
    - Else refresh timer expiry -> UPLOAD without a swap.
  - SWAP: 1 cycle. bank_sel <= ~bank_sel at the end of the cycle; -> UPLOAD.
  - UPLOAD:
    - enable=1 for exactly 64 consecutive cycles; counter runs 0..63.
    - At count 63: frame_done=1, frame_cnt+1, -> GAP.
  - GAP: enable=0 for GAP_CYCLES cycles; -> IDLE.
- Enable width is exactly 64 cycles, never more or fewer. The driver's free-running address wraps mod 64, so this keeps it aligned to cell 0 at each upload start.
- commit while in SWAP/UPLOAD/GAP sets pending. Multiple commits while pending merge into one swap.
- A commit in the same cycle as a wr_en includes that write. Writes up to and including the SWAP cycle land in the bank that is uploaded next.
- After a swap, the back bank holds the frame from two commits ago. Game logic rewrites any cells it needs changed.
- Refresh timer:
  - Counts only in IDLE; cleared on entering SWAP or UPLOAD.
  - Expiry at REFRESH_PERIOD-1.
  - Disabled when REFRESH_PERIOD=0.
- busy = (state!=IDLE) | pending.
- Reset mid-upload: enable drops immediately (async), all state clears, and the partial frame is discarded. The driver shares nrst, so both address counters restart at 0.

Optional Feature:
- SYNC_CHECK_EN defined:
  - During UPLOAD, when command==1 and address != upload counter, sync_err <= 1.
  - sync_err is sticky until nrst.
  - Also flags command==0 during any UPLOAD cycle.
- Undefined: sync_err tied 0; no checker logic.

Decomposition:
- Package maze_pkg: CELL_W, ADDR_W, cell colour constants (CELL_OFF=0, CELL_RED=1, CELL_GRN=2, CELL_BOTH=3), FSM state encoding.
- One sub-module: maze_frame_bank, a dual-bank 64x2 RAM with one write port (back bank) and one async read port (front bank), plus bank_sel toggle.
- FSM, counters and the checker stay in the top module.

Test Plan:
- Reset, write cells 0..63 = addr%4, commit -> enable high exactly 64 cycles starting 2 cycles after commit; model driver captures the pattern; frame_done once; frame_cnt=1.
- Commit during UPLOAD, then second commit -> single pending; exactly one further swap and upload after GAP_CYCLES=4 idle cycles; frame_cnt=2.
- REFRESH_PERIOD=100, no commit -> re-upload every 100+64+4 cycles; uploaded data unchanged; bank_sel unchanged.
- wr_en to cell 10 = 3 in the same cycle as commit -> uploaded cell 10 = 3. Write during UPLOAD -> not in the current frame; appears in the frame after the next commit.
- Assert nrst at upload count 30 -> enable=0 the same cycle; frame_cnt=0. Next commit uploads a full 64 cycles aligned to address 0.
- SYNC_CHECK_EN: model driver skips one address at count 20 -> sync_err=1 and stays high; without the macro sync_err stays 0.
